// File: rtl/m_seq_checker.sv
// m_seq_checker: receive-side PN (m-sequence) checker with lock detect.
// Seeds a local LFSR from received bits, verifies, locks, then counts bit errors.
//
// Ports:
//   clk       bit clock
//   rst       asynchronous reset, active-high
//   m         received sequence bit
//   m_vld     m is sampled only on rising edges with m_vld=1
//   clr       synchronous clear; counters to 0, FSM to SEED, sr kept
//   locked    high while the FSM is in LOCKED
//   err_pulse one-cycle pulse per errored bit while locked
//   err_cnt   errors since reset/clr, saturating
//
// Build option: define MSEQ_CHK_AUTOSYNC_EN to enable windowed loss-of-lock
// with automatic resync; otherwise LOCKED is sticky until rst or clr.
module m_seq_checker #(
  parameter int unsigned ORDER = 7,
  parameter logic [ORDER-1:0] TAPS = 7'b1100000,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN_LEN = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m,
  input  logic             m_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned BW = $clog2(ORDER + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } st_t;

  st_t            st;
  logic [ORDER-1:0] sr;
  logic [BW-1:0]  bcnt;
  logic [MW-1:0]  mcnt;

  logic             pred;
  logic             hit;
  logic [ORDER-1:0] sr_in;
  logic [ORDER-1:0] sr_free;
  logic             blast;
  logic             mlast;
  logic             err_sat;

  assign pred    = ^(sr & TAPS);
  assign hit     = (m == pred);
  assign sr_in   = {sr[ORDER-2:0], m};
  assign sr_free = {sr[ORDER-2:0], pred};
  assign blast   = (bcnt == BW'(ORDER - 1));
  assign mlast   = (mcnt == MW'(LOCK_CNT - 1));
  assign err_sat = &err_cnt;

`ifdef MSEQ_CHK_AUTOSYNC_EN
  localparam int unsigned WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned EW = $clog2(LOSS_THR + 1);

  logic [WW-1:0] wcnt;
  logic [EW-1:0] werr;
  logic          wlast;
  logic          loss;

  assign wlast = (wcnt == WW'(WIN_LEN - 1));
  // threshold is hit by the error arriving on this bit
  assign loss  = !hit && (werr == EW'(LOSS_THR - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= SEED;
      sr        <= '0;
      bcnt      <= '0;
      mcnt      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
`ifdef MSEQ_CHK_AUTOSYNC_EN
      wcnt      <= '0;
      werr      <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (clr) begin
        st      <= SEED;
        bcnt    <= '0;
        mcnt    <= '0;
        locked  <= 1'b0;
        err_cnt <= '0;
`ifdef MSEQ_CHK_AUTOSYNC_EN
        wcnt    <= '0;
        werr    <= '0;
`endif
      end else if (m_vld) begin
        unique case (st)
          SEED: begin
            sr <= sr_in;
            if (blast) begin
              bcnt <= '0;
              // all-zero seed would lock the LFSR at zero
              if (|sr_in) begin
                st   <= VERIFY;
                mcnt <= '0;
              end
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
          VERIFY: begin
            sr <= sr_in;
            if (hit) begin
              if (mlast) begin
                st     <= LOCKED;
                locked <= 1'b1;
                mcnt   <= '0;
              end else begin
                mcnt <= mcnt + MW'(1);
              end
            end else begin
              st   <= SEED;
              bcnt <= '0;
              mcnt <= '0;
            end
          end
          LOCKED: begin
            // free-run on prediction so line errors never reach sr
            sr <= sr_free;
            if (!hit) begin
              err_pulse <= 1'b1;
              if (!err_sat) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
            end
`ifdef MSEQ_CHK_AUTOSYNC_EN
            if (loss) begin
              st     <= SEED;
              locked <= 1'b0;
              bcnt   <= '0;
              wcnt   <= '0;
              werr   <= '0;
            end else if (wlast) begin
              wcnt <= '0;
              werr <= '0;
            end else begin
              wcnt <= wcnt + WW'(1);
              if (!hit) begin
                werr <= werr + EW'(1);
              end
            end
`endif
          end
          default: begin
            st     <= SEED;
            locked <= 1'b0;
            bcnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_seq_checker.sv
// tb_m_seq_checker: directed self-checking bench for m_seq_checker.
// Drives a local PN generator, injects bit errors, checks lock and error counts.
module tb_m_seq_checker;

  localparam logic [6:0] TAPS = 7'b1100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       m;
  logic       m_vld;
  logic       clr;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_cnt;

  int         ncmp = 0;
  int         nerr = 0;
  int         pulses;
  logic       anylock;
  logic [6:0] g = 7'h5A;

  always #5 clk = ~clk;

  m_seq_checker #(
    .ORDER(7),
    .TAPS(TAPS),
    .LOCK_CNT(16),
    .WIN_LEN(64),
    .LOSS_THR(8),
    .ERR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m(m),
    .m_vld(m_vld),
    .clr(clr),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    m = b;
    m_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic good();
    logic b;
    b = ^(g & TAPS);
    g = {g[5:0], b};
    step(b, 1'b1);
  endtask

  task automatic bad();
    logic b;
    b = ^(g & TAPS);
    g = {g[5:0], b};
    step(~b, 1'b1);
  endtask

  task automatic clr_cycle();
    clr = 1'b1;
    good();
    clr = 1'b0;
  endtask

  task automatic relock(input string tag);
    repeat (22) good();
    chk({tag, "_pre"}, 32'(locked), 32'd0);
    good();
    chk(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    m = 1'b0;
    m_vld = 1'b0;
    clr = 1'b0;
    #12;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    relock("lock1");

    pulses = 0;
    repeat (200) begin
      good();
      pulses += int'(err_pulse);
    end
    chk("clean_pulses", 32'(pulses), 32'd0);
    chk("clean_cnt", 32'(err_cnt), 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);

    bad();
    chk("one_pulse", 32'(err_pulse), 32'd1);
    chk("one_cnt", 32'(err_cnt), 32'd1);
    good();
    chk("one_pulse_end", 32'(err_pulse), 32'd0);
    pulses = 0;
    repeat (100) begin
      good();
      pulses += int'(err_pulse);
    end
    chk("no_trail", 32'(pulses), 32'd0);
    chk("one_cnt_hold", 32'(err_cnt), 32'd1);
    chk("one_locked", 32'(locked), 32'd1);

    bad();
    step(1'b1, 1'b0);
    chk("hold_pulse", 32'(err_pulse), 32'd0);
    chk("hold_cnt", 32'(err_cnt), 32'd2);
    repeat (10) good();
    chk("hold_sr", 32'(err_cnt), 32'd2);

    clr_cycle();
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    relock("relock_clr");

    clr_cycle();
    repeat (12) good();
    bad();
    relock("verify_miss");

`ifdef MSEQ_CHK_AUTOSYNC_EN
    clr_cycle();
    relock("as_lock");
    repeat (7) bad();
    chk("as_7_locked", 32'(locked), 32'd1);
    chk("as_7_cnt", 32'(err_cnt), 32'd7);
    bad();
    chk("as_8_locked", 32'(locked), 32'd0);
    chk("as_8_cnt", 32'(err_cnt), 32'd8);
    chk("as_8_pulse", 32'(err_pulse), 32'd1);
    relock("as_relock");
    chk("as_kept_cnt", 32'(err_cnt), 32'd8);
    repeat (7) bad();
    repeat (60) good();
    bad();
    chk("win_wrap", 32'(locked), 32'd1);
    chk("win_sat", 32'(err_cnt), 32'd15);
`else
    clr_cycle();
    relock("st_lock");
    repeat (15) bad();
    chk("st_15", 32'(err_cnt), 32'd15);
    repeat (5) bad();
    chk("st_sat", 32'(err_cnt), 32'd15);
    chk("st_locked", 32'(locked), 32'd1);
    chk("st_pulse", 32'(err_pulse), 32'd1);
    clr_cycle();
    chk("st_clr_cnt", 32'(err_cnt), 32'd0);
    chk("st_clr_lock", 32'(locked), 32'd0);
    relock("st_relock");
`endif

    rst = 1'b1;
    #3;
    rst = 1'b0;
    anylock = 1'b0;
    repeat (1000) begin
      step(1'b0, 1'b1);
      anylock = anylock | locked;
    end
    chk("zero_nolock", 32'(anylock), 32'd0);
    clr_cycle();
    relock("after_zero");

    repeat (4) begin
      bad();
      repeat (3) good();
    end
    bad();
    chk("pre_rst_cnt", 32'(err_cnt), 32'd5);
    chk("pre_rst_pulse", 32'(err_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_pulse", 32'(err_pulse), 32'd0);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    #3;
    rst = 1'b0;
    relock("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
